// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered digit store.
// Host writes land in a shadow buffer that is committed to the displayed buffer at frame boundaries.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int AW           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    output logic [3:0]            num,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int CW         = $clog2(SLOT_CYCLES);
    localparam int BLANK_LAST = BLANK_CYCLES - 1;
    localparam int SHOW_LAST  = SLOT_CYCLES - BLANK_CYCLES - 1;

    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   DIGIT_CNT = (AW + 1)'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [AW-1:0]           idx;
    logic [AW-1:0]           idx_nxt;
    logic                    wrap;
    logic                    commit;
    logic                    wr_ok;
    logic [3:0]              shadow     [NUM_DIGITS];
    logic [3:0]              active     [NUM_DIGITS];
    logic [3:0]              active_nxt [NUM_DIGITS];
    logic [3:0]              num_nxt;
    logic [NUM_DIGITS-1:0]   en_nxt;

    assign wr_ok  = wr_en && ({1'b0, wr_addr} < DIGIT_CNT);
    assign commit = wrap && pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Dropping ena wins over every sequencing decision, including the frame wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_LAST)) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == CW'(SHOW_LAST)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == LAST_IDX) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they register on the same edge as the state.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            active_nxt[i] = commit ? shadow[i] : active[i];
        end
        num_nxt = 4'd0;
        en_nxt  = '1;
        case (state_nxt)
            BLANK: num_nxt = active_nxt[idx_nxt];
            SHOW: begin
                num_nxt         = active_nxt[idx_nxt];
                en_nxt[idx_nxt] = 1'b0;
            end
            default: ;
        endcase
    end

    // The commit copies the pre-write shadow, so a colliding write stays pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num        <= 4'd0;
            digit_en_n <= '1;
            frame_tick <= 1'b0;
            pending    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
        end else begin
            num        <= num_nxt;
            digit_en_n <= en_nxt;
            frame_tick <= wrap;
            pending    <= wr_ok | (pending & ~commit);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active[i] <= active_nxt[i];
            end
            if (wr_ok) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

endmodule
